// File: rtl/ddr2_fifo_pkg.sv
// Shared definitions for the DDR2 FIFO datapaths: MIG command codes,
// read-stream FSM encoding and default burst geometry.
package ddr2_fifo_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam int DEF_BEATS_PER_RD = 2;
   localparam int DEF_ADDR_STEP    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/ddr2_rd_stream_if.sv
// MIG app command/read-data signals plus the user stream, bundled for ddr2_rd_stream.
// master = the streamer, slave = the MIG/user side.
interface ddr2_rd_stream_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 31
) ();

   logic [2:0]            app_af_cmd;
   logic [ADDR_WIDTH-1:0] app_af_addr;
   logic                  app_af_wren;
   logic                  app_af_afull;
   logic                  rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data_fifo_out;
   logic [DATA_WIDTH-1:0] usr_dout;
   logic                  usr_valid;
   logic                  usr_ready;

   modport master (
      output app_af_cmd, app_af_addr, app_af_wren, usr_dout, usr_valid,
      input  app_af_afull, rd_data_valid, rd_data_fifo_out, usr_ready
   );

   modport slave (
      input  app_af_cmd, app_af_addr, app_af_wren, usr_dout, usr_valid,
      output app_af_afull, rd_data_valid, rd_data_fifo_out, usr_ready
   );

endinterface

// File: rtl/ddr2_rd_buf.sv
// Synchronous first-word-fall-through FIFO holding returned MIG read beats.
// A write while full is dropped unless a read frees the slot in the same cycle.
module ddr2_rd_buf
   import ddr2_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int AW         = 5
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           count
);

   localparam int DEPTH = 1 << AW;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           count_q, count_d;
   logic                  wr_ok;
   logic                  rd_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      rd_ok    = rd_en && !empty;
      wr_ok    = wr_en && (!full || rd_ok);
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage carries no reset; occupancy alone defines validity
   always_ff @(posedge clk_in) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/ddr2_rd_stream.sv
// Issues BL4 reads over a contiguous window and streams returned beats out with valid/ready.
// Optional DDR2_RD_CHECK_EN adds a pattern checker with a saturating error counter.
module ddr2_rd_stream
   import ddr2_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 31,
   parameter int BEATS_PER_RD = DEF_BEATS_PER_RD,
   parameter int ADDR_STEP    = DEF_ADDR_STEP,
   parameter int BUF_AW       = 5
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  phy_init_done,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [15:0]           num_cmds,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf_err,
`ifdef DDR2_RD_CHECK_EN
   output logic [15:0]           chk_err_cnt,
`endif
   ddr2_rd_stream_if.master      bus
);

   localparam int                CRED_W   = BUF_AW + 1;
   localparam logic [CRED_W-1:0] CRED_RST = CRED_W'(1 << BUF_AW);
   localparam logic [CRED_W-1:0] BEATS_C  = CRED_W'(BEATS_PER_RD);

   rd_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           cmds_left_q, cmds_left_d;
   logic [31:0]           beats_left_q, beats_left_d;
   logic [CRED_W-1:0]     credits_q, credits_d;
   logic                  ovf_err_q, ovf_err_d;

   logic                  start_ok;
   logic                  issue;
   logic                  pop;
   logic                  buf_wr;
   logic [DATA_WIDTH-1:0] buf_rd_data;
   logic                  buf_full;
   logic                  buf_empty;
   logic [BUF_AW:0]       buf_count;

   assign start_ok = (state_q == ST_IDLE) && start && phy_init_done && (num_cmds != 16'd0);
   assign pop      = !buf_empty && bus.usr_ready;
   // beats landing while idle belong to an aborted transfer and are discarded
   assign buf_wr   = bus.rd_data_valid && (state_q != ST_IDLE);

   ddr2_rd_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (BUF_AW)
   ) u_buf (
      .clk_in  (clk_in),
      .reset   (reset),
      .wr_en   (buf_wr),
      .wr_data (bus.rd_data_fifo_out),
      .rd_en   (pop),
      .rd_data (buf_rd_data),
      .full    (buf_full),
      .empty   (buf_empty),
      .count   (buf_count)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cmds_left_d  = cmds_left_q;
      beats_left_d = beats_left_q;
      issue        = 1'b0;
      if (pop) beats_left_d = beats_left_q - 32'd1;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               addr_d       = start_addr;
               cmds_left_d  = num_cmds;
               beats_left_d = 32'(num_cmds) * 32'(BEATS_PER_RD);
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // a command is only sent once its whole burst is guaranteed buffer space
            if (!bus.app_af_afull && (credits_q >= BEATS_C)) begin
               issue       = 1'b1;
               addr_d      = addr_q + ADDR_WIDTH'(ADDR_STEP);
               cmds_left_d = cmds_left_q - 16'd1;
               if (cmds_left_q == 16'd1) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (beats_left_q == 32'd0) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      credits_d = credits_q;
      if (issue) credits_d = credits_d - BEATS_C;
      if (pop)   credits_d = credits_d + CRED_W'(1);
      ovf_err_d = ovf_err_q | (buf_wr && buf_full && !pop);
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         cmds_left_q  <= '0;
         beats_left_q <= '0;
         credits_q    <= CRED_RST;
         ovf_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cmds_left_q  <= cmds_left_d;
         beats_left_q <= beats_left_d;
         credits_q    <= credits_d;
         ovf_err_q    <= ovf_err_d;
      end
   end

   assign bus.app_af_cmd  = CMD_READ;
   assign bus.app_af_addr = addr_q;
   assign bus.app_af_wren = issue;
   assign bus.usr_valid   = !buf_empty;
   assign bus.usr_dout    = (buf_count != '0) ? buf_rd_data : '0;
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);
   assign ovf_err         = ovf_err_q;

`ifdef DDR2_RD_CHECK_EN
   logic [31:0] chk_cnt_q, chk_cnt_d;
   logic [15:0] chk_err_q, chk_err_d;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] chk_pattern(input logic [31:0] c);
      logic [63:0] p;
      p = {~c, c};
      return DATA_WIDTH'(p);
   endfunction

   always_comb begin
      chk_cnt_d = chk_cnt_q;
      chk_err_d = chk_err_q;
      if (start_ok) begin
         chk_cnt_d = '0;
      end else if (pop) begin
         chk_cnt_d = chk_cnt_q + 32'd1;
         if (buf_rd_data != chk_pattern(chk_cnt_q)) chk_err_d = sat_inc16(chk_err_q);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         chk_cnt_q <= '0;
         chk_err_q <= '0;
      end else begin
         chk_cnt_q <= chk_cnt_d;
         chk_err_q <= chk_err_d;
      end
   end

   assign chk_err_cnt = chk_err_q;
`endif

endmodule

// File: tb/tb_ddr2_rd_stream.sv
// Directed bench for ddr2_rd_stream with a small MIG read-return model (2 beats, 8 cycles after each command).
`timescale 1ns/1ps
module tb_ddr2_rd_stream;
   import ddr2_fifo_pkg::*;

   logic        clk_in;
   logic        reset;
   logic        phy_init_done;
   logic        start;
   logic [30:0] start_addr;
   logic [15:0] num_cmds;
   logic        busy;
   logic        done;
   logic        ovf_err;
`ifdef DDR2_RD_CHECK_EN
   logic [15:0] chk_err_cnt;
`endif

   int checks;
   int errors;

   int          cyc;
   int          due_q[$];
   logic [31:0] mdl_cnt;
   int          corrupt_beat;
   logic [30:0] wren_log[$];
   logic [63:0] pop_log[$];
   int          done_cnt;

   ddr2_rd_stream_if #(.DATA_WIDTH(64), .ADDR_WIDTH(31)) bus ();

   ddr2_rd_stream dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .phy_init_done (phy_init_done),
      .start         (start),
      .start_addr    (start_addr),
      .num_cmds      (num_cmds),
      .busy          (busy),
      .done          (done),
      .ovf_err       (ovf_err),
`ifdef DDR2_RD_CHECK_EN
      .chk_err_cnt   (chk_err_cnt),
`endif
      .bus           (bus)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   function automatic logic [63:0] pat(input int k);
      logic [31:0] c;
      c = 32'(k);
      return {~c, c};
   endfunction

   // monitor at negedge, MIG return driver just after posedge
   initial begin
      cyc = 0;
      mdl_cnt = '0;
      done_cnt = 0;
      bus.rd_data_valid = 1'b0;
      bus.rd_data_fifo_out = '0;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (bus.app_af_wren) begin
            wren_log.push_back(bus.app_af_addr);
            due_q.push_back(cyc + 8);
            due_q.push_back(cyc + 8);
         end
         if (bus.usr_valid && bus.usr_ready) pop_log.push_back(bus.usr_dout);
         if (done) done_cnt++;
         if (start && !busy && phy_init_done && num_cmds != 16'd0 && !reset) mdl_cnt = '0;
         @(posedge clk_in);
         #1;
         if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
            bus.rd_data_valid = 1'b1;
            bus.rd_data_fifo_out = {~mdl_cnt, mdl_cnt} ^ ((int'(mdl_cnt) == corrupt_beat) ? 64'h1 : 64'h0);
            void'(due_q.pop_front());
            mdl_cnt++;
         end else begin
            bus.rd_data_valid = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_start(input logic [30:0] a, input logic [15:0] n);
      start = 1'b1;
      start_addr = a;
      num_cmds = n;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      @(negedge clk_in);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (bus.app_af_wren !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b want 0", bus.app_af_wren); end
      checks++; if (bus.app_af_cmd !== 3'b001) begin errors++; $display("FAIL rst_cmd: got %b want 001", bus.app_af_cmd); end
      checks++; if (bus.app_af_addr !== 31'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.app_af_addr); end
      checks++; if (bus.usr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.usr_valid); end
      checks++; if (bus.usr_dout !== 64'h0) begin errors++; $display("FAIL rst_dout: got %h want 0", bus.usr_dout); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf_err); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int w0, p0, d0, bad;
      bit ok;
      logic [30:0] ea;
      phy_init_done = 1'b1;
      bus.usr_ready = 1'b1;
      bus.app_af_afull = 1'b0;
      w0 = wren_log.size(); p0 = pop_log.size(); d0 = done_cnt;
      do_start(31'h100, 16'd4);
      @(negedge clk_in);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
      wait_done(d0, 300, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: got %b want 1", ok); end
      repeat (4) tick();
      checks++; if (wren_log.size() - w0 != 4) begin errors++; $display("FAIL basic_ncmd: got %0d want 4", wren_log.size() - w0); end
      for (int k = 0; k < 4 && w0 + k < wren_log.size(); k++) begin
         ea = 31'h100 + 31'(4 * k);
         checks++; if (wren_log[w0+k] !== ea) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", k, wren_log[w0+k], ea); end
      end
      checks++; if (pop_log.size() - p0 != 8) begin errors++; $display("FAIL basic_nbeat: got %0d want 8", pop_log.size() - p0); end
      bad = 0;
      for (int k = 0; k < 8 && p0 + k < pop_log.size(); k++) if (pop_log[p0+k] !== pat(k)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_data: got %0d bad beats want 0", bad); end
      checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
      @(negedge clk_in);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
      tick();
   endtask

   task automatic test_backpressure();
      int w0, p0, d0, bad;
      bit ok;
      bus.usr_ready = 1'b0;
      w0 = wren_log.size(); p0 = pop_log.size(); d0 = done_cnt;
      do_start(31'h2000, 16'd40);
      repeat (60) tick();
      checks++; if (wren_log.size() - w0 != 16) begin errors++; $display("FAIL bp_stall_cmds: got %0d want 16", wren_log.size() - w0); end
      @(negedge clk_in);
      checks++; if (bus.app_af_wren !== 1'b0) begin errors++; $display("FAIL bp_wren_low: got %b want 0", bus.app_af_wren); end
      checks++; if (bus.usr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.usr_valid); end
      tick();
      bus.usr_ready = 1'b1;
      wait_done(d0, 1500, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %b want 1", ok); end
      repeat (4) tick();
      checks++; if (wren_log.size() - w0 != 40) begin errors++; $display("FAIL bp_ncmd: got %0d want 40", wren_log.size() - w0); end
      bad = 0;
      for (int k = 0; k < 40 && w0 + k < wren_log.size(); k++) if (wren_log[w0+k] !== 31'h2000 + 31'(4 * k)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_addr: got %0d bad addrs want 0", bad); end
      checks++; if (pop_log.size() - p0 != 80) begin errors++; $display("FAIL bp_nbeat: got %0d want 80", pop_log.size() - p0); end
      bad = 0;
      for (int k = 0; k < 80 && p0 + k < pop_log.size(); k++) if (pop_log[p0+k] !== pat(k)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_data: got %0d bad beats want 0", bad); end
      checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b want 0", ovf_err); end
   endtask

   task automatic test_afull();
      int w0, p0, d0, n1, bad, stall_bad;
      bit ok;
      bus.usr_ready = 1'b1;
      w0 = wren_log.size(); p0 = pop_log.size(); d0 = done_cnt;
      do_start(31'h7FFF_FFF8, 16'd12);
      repeat (3) tick();
      bus.app_af_afull = 1'b1;
      stall_bad = 0;
      n1 = 0;
      repeat (10) begin
         @(negedge clk_in);
         if (bus.app_af_wren) stall_bad++;
         tick();
      end
      n1 = wren_log.size() - w0;
      bus.app_af_afull = 1'b0;
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL afull_wren: got %0d wren cycles want 0", stall_bad); end
      checks++; if (!(n1 > 0 && n1 < 12)) begin errors++; $display("FAIL afull_mid: got %0d cmds before release want 1..11", n1); end
      wait_done(d0, 400, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL afull_timeout: got %b want 1", ok); end
      repeat (4) tick();
      checks++; if (wren_log.size() - w0 != 12) begin errors++; $display("FAIL afull_ncmd: got %0d want 12", wren_log.size() - w0); end
      bad = 0;
      for (int k = 0; k < 12 && w0 + k < wren_log.size(); k++) if (wren_log[w0+k] !== 31'h7FFF_FFF8 + 31'(4 * k)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL afull_addr: got %0d bad addrs want 0", bad); end
      if (w0 + 2 < wren_log.size()) begin
         checks++; if (wren_log[w0+2] !== 31'h0) begin errors++; $display("FAIL afull_wrap: got %h want 0", wren_log[w0+2]); end
      end
      bad = 0;
      for (int k = 0; k < 24 && p0 + k < pop_log.size(); k++) if (pop_log[p0+k] !== pat(k)) bad++;
      checks++; if (bad != 0 || pop_log.size() - p0 != 24) begin errors++; $display("FAIL afull_data: got %0d beats %0d bad want 24 beats 0 bad", pop_log.size() - p0, bad); end
   endtask

   task automatic test_edge_starts();
      int w0, p0, d0, bz0, bz1;
      bit ok;
      w0 = wren_log.size(); d0 = done_cnt;
      do_start(31'h600, 16'd0);
      bz0 = 0;
      repeat (5) begin @(negedge clk_in); if (busy) bz0++; tick(); end
      phy_init_done = 1'b0;
      do_start(31'h600, 16'd5);
      bz1 = 0;
      repeat (5) begin @(negedge clk_in); if (busy) bz1++; tick(); end
      phy_init_done = 1'b1;
      checks++; if (bz0 != 0) begin errors++; $display("FAIL edge_zero_busy: got %0d busy cycles want 0", bz0); end
      checks++; if (bz1 != 0) begin errors++; $display("FAIL edge_phy_busy: got %0d busy cycles want 0", bz1); end
      checks++; if (done_cnt != d0 || wren_log.size() != w0) begin errors++; $display("FAIL edge_noop: got %0d done %0d cmds want 0 0", done_cnt - d0, wren_log.size() - w0); end
      w0 = wren_log.size(); p0 = pop_log.size(); d0 = done_cnt;
      do_start(31'h300, 16'd3);
      tick();
      do_start(31'h900, 16'd9);
      wait_done(d0, 300, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL edge_timeout: got %b want 1", ok); end
      repeat (4) tick();
      checks++; if (wren_log.size() - w0 != 3) begin errors++; $display("FAIL edge_ncmd: got %0d want 3", wren_log.size() - w0); end
      if (w0 + 2 < wren_log.size()) begin
         checks++; if (wren_log[w0+2] !== 31'h308) begin errors++; $display("FAIL edge_addr: got %h want 308", wren_log[w0+2]); end
      end
      checks++; if (pop_log.size() - p0 != 6) begin errors++; $display("FAIL edge_nbeat: got %0d want 6", pop_log.size() - p0); end
   endtask

   task automatic test_reset_mid();
      int w0, p0, d0, bad, stray_bad;
      bit ok;
      bus.usr_ready = 1'b1;
      w0 = wren_log.size();
      do_start(31'h400, 16'd8);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (wren_log.size() - w0 >= 3) begin ok = 1'b1; break; end
         tick();
      end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_progress: got %b want 1", ok); end
      reset = 1'b1;
      tick();
      @(negedge clk_in);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
      checks++; if (bus.app_af_wren !== 1'b0) begin errors++; $display("FAIL rmid_wren: got %b want 0", bus.app_af_wren); end
      checks++; if (bus.app_af_addr !== 31'h0) begin errors++; $display("FAIL rmid_addr: got %h want 0", bus.app_af_addr); end
      checks++; if (bus.usr_valid !== 1'b0 || bus.usr_dout !== 64'h0) begin errors++; $display("FAIL rmid_stream: got %b/%h want 0/0", bus.usr_valid, bus.usr_dout); end
      checks++; if (done !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL rmid_flags: got %b/%b want 0/0", done, ovf_err); end
      tick();
      reset = 1'b0;
      stray_bad = 0;
      repeat (30) begin @(negedge clk_in); if (bus.usr_valid || busy) stray_bad++; tick(); end
      checks++; if (stray_bad != 0) begin errors++; $display("FAIL rmid_stray: got %0d cycles with data want 0", stray_bad); end
      w0 = wren_log.size(); p0 = pop_log.size(); d0 = done_cnt;
      do_start(31'h500, 16'd2);
      wait_done(d0, 200, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rmid_timeout: got %b want 1", ok); end
      repeat (4) tick();
      checks++; if (wren_log.size() - w0 != 2) begin errors++; $display("FAIL rmid_ncmd: got %0d want 2", wren_log.size() - w0); end
      if (w0 + 1 < wren_log.size()) begin
         checks++; if (wren_log[w0] !== 31'h500 || wren_log[w0+1] !== 31'h504) begin errors++; $display("FAIL rmid_addr2: got %h/%h want 500/504", wren_log[w0], wren_log[w0+1]); end
      end
      bad = 0;
      for (int k = 0; k < 4 && p0 + k < pop_log.size(); k++) if (pop_log[p0+k] !== pat(k)) bad++;
      checks++; if (bad != 0 || pop_log.size() - p0 != 4) begin errors++; $display("FAIL rmid_data: got %0d beats %0d bad want 4 beats 0 bad", pop_log.size() - p0, bad); end
   endtask

`ifdef DDR2_RD_CHECK_EN
   task automatic test_checker();
      int p0, d0;
      bit ok;
      checks++; if (chk_err_cnt !== 16'd0) begin errors++; $display("FAIL chk_clean: got %0d want 0", chk_err_cnt); end
      corrupt_beat = 5;
      p0 = pop_log.size(); d0 = done_cnt;
      do_start(31'h800, 16'd4);
      wait_done(d0, 300, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL chk_timeout: got %b want 1", ok); end
      checks++; if (chk_err_cnt !== 16'd1) begin errors++; $display("FAIL chk_cnt: got %0d want 1", chk_err_cnt); end
      repeat (4) tick();
      if (p0 + 5 < pop_log.size()) begin
         checks++; if (pop_log[p0+5] !== (pat(5) ^ 64'h1)) begin errors++; $display("FAIL chk_beat5: got %h want %h", pop_log[p0+5], pat(5) ^ 64'h1); end
      end
      corrupt_beat = -1;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      corrupt_beat = -1;
      reset = 1'b1;
      phy_init_done = 1'b0;
      start = 1'b0;
      start_addr = '0;
      num_cmds = '0;
      bus.app_af_afull = 1'b0;
      bus.usr_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_afull();
      test_edge_starts();
      test_reset_mid();
`ifdef DDR2_RD_CHECK_EN
      test_checker();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr2_rd_stream.md
Name: ddr2_rd_stream

Overview:
- Read-side counterpart of the DDR2 write-FIFO path.
- Issues BL4 read commands to the MIG app address FIFO over a contiguous address window.
- Collects returned read beats into an internal buffer and streams them to the user with valid/ready.
- Credit-based issue, so returned data can never overflow the buffer.

Parameters:
- DATA_WIDTH, 64, width of one MIG read beat (2x 32-bit DQ).
- ADDR_WIDTH, 31, width of the app_af_addr field.
- BEATS_PER_RD, 2, beats returned per read command (BL4).
- ADDR_STEP, 4, column-address increment per read command.
- BUF_AW, 5, log2 of buffer depth (32 entries).

Ports:
- clk_in  in  1  system clock, same domain as MIG app interface.
- reset  in  1  synchronous, active-high reset.
- phy_init_done  in  1  MIG calibration complete.
- start  in  1  one-cycle pulse; latches start_addr and num_cmds.
- start_addr  in  ADDR_WIDTH  first read address.
- num_cmds  in  16  number of read commands; 0 means no-op.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the last beat is accepted by the user.
- app_af_cmd  out  3  command code; always CMD_READ when wren is high.
- app_af_addr  out  ADDR_WIDTH  command address.
- app_af_wren  out  1  command write strobe.
- app_af_afull  in  1  address FIFO almost full.
- rd_data_valid  in  1  read beat present.
- rd_data_fifo_out  in  DATA_WIDTH  read beat data.
- usr_dout  out  DATA_WIDTH  streamed data.
- usr_valid  out  1  usr_dout valid.
- usr_ready  in  1  user accepts beat.
- ovf_err  out  1  sticky: rd_data_valid arrived while the buffer was full.

Behaviour:
- Reset values: busy=0, done=0, app_af_wren=0, app_af_cmd=CMD_READ, app_af_addr=0, usr_valid=0, usr_dout=0, ovf_err=0.
- Reset takes effect mid-transfer: FSM goes to IDLE, counters and buffer are cleared, and stray rd_data_valid beats are discarded.
- FSM states:
  - IDLE: on start with num_cmds!=0 and phy_init_done=1, latch inputs and go to ISSUE. Otherwise start is ignored and done stays 0.
  - ISSUE: each cycle, if app_af_afull=0 and credits>=BEATS_PER_RD, assert app_af_wren with the current addr. Then addr+=ADDR_STEP (wraps modulo 2^ADDR_WIDTH), cmds_left-=1, credits-=BEATS_PER_RD. When the last command is issued, go to DRAIN.
  - DRAIN: wait until beats_left==0, then go to DONE.
  - DONE: pulse done for 1 cycle, then go to IDLE.
- credits:
  - Reset value is 2^BUF_AW.
  - Decrements by BEATS_PER_RD on issue and increments by 1 on each user pop.
  - Issue and pop in the same cycle apply both updates.
- beats_left: loaded with num_cmds*BEATS_PER_RD and decremented on each user handshake (usr_valid and usr_ready).
- Buffer:
  - Write on rd_data_valid; read on usr_valid and usr_ready.
  - First-word-fall-through: a beat written in cycle N is visible on usr_dout/usr_valid in cycle N+1.
  - Simultaneous read and write while full is legal.
- Write when full with no pop in that cycle: the beat is dropped and ovf_err is set (cleared only by reset). This cannot occur with correct credits.
- busy is 1 in ISSUE, DRAIN and DONE.
- start while busy is ignored.
- usr_ready held low stalls issue via credits. No data is lost and app_af_wren stays low.

Optional Feature:
- Macro DDR2_RD_CHECK_EN. When defined:
  - Adds output chk_err_cnt[15:0] (reset 0).
  - Each popped beat is compared to the expected pattern {~cnt[31:0], cnt[31:0]}, where cnt starts at 0 on start and increments per beat.
  - On mismatch, chk_err_cnt increments, saturating at 16'hFFFF.
- When undefined: the port and logic are absent.

Decomposition:
- Package ddr2_fifo_pkg holds:
  - CMD_WRITE=3'b000 and CMD_READ=3'b001.
  - The FSM state encoding (IDLE/ISSUE/DRAIN/DONE).
  - Default BEATS_PER_RD and ADDR_STEP.
- Sub-module ddr2_rd_buf: parameterised synchronous FWFT FIFO with full, empty and a count output. The top contains the FSM, counters and the credit logic.

Test Plan:
- Basic read:
  - Stimulus: phy_init_done=1, start with start_addr=0x100, num_cmds=4, usr_ready=1, model returns 2 beats 8 cycles after each command.
  - Required response: 4 wren cycles at addr 0x100/0x104/0x108/0x10C, 8 beats out in order, a single done pulse, then busy=0.
- Backpressure:
  - Stimulus: num_cmds=40, usr_ready=0.
  - Required response: exactly 16 commands issued, then app_af_wren stays 0. Raising usr_ready completes all 80 beats with ovf_err=0.
- afull stall:
  - Stimulus: app_af_afull=1 for 10 cycles mid-transfer.
  - Required response: no wren during the stall, and the address sequence continues without a gap.
- Edge starts:
  - Stimulus: start with num_cmds=0, and separately start with phy_init_done=0.
  - Required response: busy stays 0 and no done pulse in either case. A start pulse while busy does not change addr or counts.
- Reset mid-transfer:
  - Stimulus: assert reset after 3 of 8 commands.
  - Required response: all outputs return to reset values on the next edge, and a subsequent start with num_cmds=2 completes normally.
- Checker (DDR2_RD_CHECK_EN defined):
  - Stimulus: corrupt beat 5.
  - Required response: chk_err_cnt=1 at done.
